// File: rtl/seq_match_pkg.sv
// Shared types and helpers for the serial pattern-match controller.
// State encoding is visible on the state output, so values are fixed here.
package seq_match_pkg;

    localparam int unsigned LEN_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_ARMED = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StReady = ST_READY,
        StArmed = ST_ARMED,
        StDone  = ST_DONE
    } state_e;

    // Length 0 means a 1-bit pattern; anything longer than the window is cut to fit.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int unsigned     max_len);
        if (len == '0) return LEN_W'(1);
        if (32'(len) > max_len) return LEN_W'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Host/stream-side bundle of the pattern-match controller.
import seq_match_pkg::*;

interface seq_match_ctrl_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_limit;
    logic             arm;
    logic             disarm;
    logic             in_valid;
    logic             in;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic [1:0]       state;

    modport master (
        output cfg_valid, cfg_pat, cfg_len, cfg_limit, arm, disarm, in_valid, in,
        input  cfg_ready, match, match_cnt, done, state
    );

    modport slave (
        input  cfg_valid, cfg_pat, cfg_len, cfg_limit, arm, disarm, in_valid, in,
        output cfg_ready, match, match_cnt, done, state
    );
endinterface

// File: rtl/seq_window_cmp.sv
// Serial history window with fill tracking and a length-masked pattern compare.
import seq_match_pkg::*;

module seq_window_cmp #(
    parameter int unsigned PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             in,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);
    logic [PAT_W-2:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_p1;

    // The arriving bit completes the window, so only len-1 stored bits are needed.
    assign window  = {hist_q, in};
    assign fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit = shift_en && (fill_p1 >= {1'b0, len}) && (((window ^ pat) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= window[PAT_W-2:0];
            if (fill_q != LEN_W'(PAT_W)) fill_q <= fill_q + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern detector controller: config capture, arm/disarm FSM,
// saturating match counter with optional stop-at-limit.
import seq_match_pkg::*;

module seq_match_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    seq_match_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             cfg_fire;
    logic             clr;
    logic             shift_en;
    logic             hit;

    assign bus.cfg_ready = (state_q != StArmed);
    assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
    assign shift_en      = (state_q == StArmed) && bus.in_valid;
    assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    seq_window_cmp #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .in       (bus.in),
        .pat      (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        case (state_q)
            StIdle: begin
                if (cfg_fire) state_d = StReady;
            end
            StReady, StDone: begin
                // A config transfer outranks arm in the same cycle.
                if (cfg_fire) begin
                    state_d = StReady;
                end else if (bus.arm) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            StArmed: begin
                if (hit) cnt_d = cnt_inc;
                // Reaching the limit outranks disarm; the match is still counted.
                if (hit && (limit_q != '0) && (cnt_inc == limit_q)) begin
                    state_d = StDone;
                end else if (bus.disarm) begin
                    state_d = StReady;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cfg_fire) begin
                pat_q   <= bus.cfg_pat;
                len_q   <= clamp_len(bus.cfg_len, PAT_W);
                limit_q <= bus.cfg_limit;
            end
        end
    end

    assign bus.match     = hit;
    assign bus.match_cnt = cnt_q;
    assign bus.done      = (state_q == StDone);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed, table-driven check of seq_match_ctrl; each row gives inputs for one cycle
// and the outputs expected just before that cycle's rising edge.
module tb_seq_match_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        string      name;
        logic       rst;
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] lim;
        logic       arm;
        logic       dis;
        logic       iv;
        logic       b;
        logic       em;
        logic [7:0] ecnt;
        logic [1:0] est;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    seq_match_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_match_ctrl #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic r, logic cv, logic [7:0] pat, logic [3:0] len,
                                logic [7:0] lim, logic arm, logic dis, logic iv, logic b,
                                logic em, logic [7:0] ecnt, logic [1:0] est);
        vec_t v;
        v.name = name; v.rst = r; v.cv = cv; v.pat = pat; v.len = len; v.lim = lim;
        v.arm = arm; v.dis = dis; v.iv = iv; v.b = b; v.em = em; v.ecnt = ecnt; v.est = est;
        return v;
    endfunction

    task automatic chk(string nm, string what, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h want %0h", nm, what, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        rst           = v.rst;
        bus.cfg_valid = v.cv;
        bus.cfg_pat   = v.pat;
        bus.cfg_len   = v.len;
        bus.cfg_limit = v.lim;
        bus.arm       = v.arm;
        bus.disarm    = v.dis;
        bus.in_valid  = v.iv;
        bus.in        = v.b;
        #1;
        chk(v.name, "match", 32'(bus.match), 32'(v.em));
        chk(v.name, "match_cnt", 32'(bus.match_cnt), 32'(v.ecnt));
        chk(v.name, "state", 32'(bus.state), 32'(v.est));
        chk(v.name, "cfg_ready", 32'(bus.cfg_ready), 32'(v.est != 2'b10));
        chk(v.name, "done", 32'(bus.done), 32'(v.est == 2'b11));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.cfg_valid = 0; bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_limit = '0;
        bus.arm = 0; bus.disarm = 0; bus.in_valid = 0; bus.in = 0;
        repeat (2) @(posedge clk);

        //                  name       rst cv pat    len lim arm dis iv b  em cnt st
        vecs.push_back(mk("rst_arm",    0, 0, 8'h00, 0,  0,  1,  0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk("rst_idle",   0, 0, 8'h00, 0,  0,  0,  0, 0, 0, 0, 0, 2'b00));
        // overlap: 101 over 1,0,1,0,1
        vecs.push_back(mk("ov_cfg",     0, 1, 8'h05, 3,  0,  0,  0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk("ov_arm",     0, 0, 8'h00, 0,  0,  1,  0, 0, 0, 0, 0, 2'b01));
        vecs.push_back(mk("ov_b1",      0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 0, 0, 2'b10));
        vecs.push_back(mk("ov_b2",      0, 0, 8'h00, 0,  0,  0,  0, 1, 0, 0, 0, 2'b10));
        vecs.push_back(mk("ov_b3",      0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 0, 2'b10));
        vecs.push_back(mk("ov_b4",      0, 0, 8'h00, 0,  0,  0,  0, 1, 0, 0, 1, 2'b10));
        vecs.push_back(mk("ov_b5",      0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 1, 2'b10));
        vecs.push_back(mk("ov_gap",     0, 0, 8'h00, 0,  0,  0,  0, 0, 1, 0, 2, 2'b10));
        vecs.push_back(mk("ov_disarm",  0, 0, 8'h00, 0,  0,  0,  1, 0, 0, 0, 2, 2'b10));
        vecs.push_back(mk("ov_held",    0, 0, 8'h00, 0,  0,  0,  0, 0, 0, 0, 2, 2'b01));
        // fill guard: 000
        vecs.push_back(mk("fg_cfg",     0, 1, 8'h00, 3,  0,  0,  0, 0, 0, 0, 2, 2'b01));
        vecs.push_back(mk("fg_arm",     0, 0, 8'h00, 0,  0,  1,  0, 0, 0, 0, 2, 2'b01));
        vecs.push_back(mk("fg_b1",      0, 0, 8'h00, 0,  0,  0,  0, 1, 0, 0, 0, 2'b10));
        vecs.push_back(mk("fg_b2",      0, 0, 8'h00, 0,  0,  0,  0, 1, 0, 0, 0, 2'b10));
        vecs.push_back(mk("fg_b3",      0, 0, 8'h00, 0,  0,  0,  0, 1, 0, 1, 0, 2'b10));
        vecs.push_back(mk("fg_b4",      0, 0, 8'h00, 0,  0,  0,  0, 1, 0, 1, 1, 2'b10));
        vecs.push_back(mk("fg_disarm",  0, 0, 8'h00, 0,  0,  0,  1, 0, 0, 0, 2, 2'b10));
        // limit: 11, limit 2
        vecs.push_back(mk("lim_cfg",    0, 1, 8'h03, 2,  2,  0,  0, 0, 0, 0, 2, 2'b01));
        vecs.push_back(mk("lim_arm",    0, 0, 8'h00, 0,  0,  1,  0, 0, 0, 0, 2, 2'b01));
        vecs.push_back(mk("lim_b1",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 0, 0, 2'b10));
        vecs.push_back(mk("lim_b2",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 0, 2'b10));
        vecs.push_back(mk("lim_b3",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 1, 2'b10));
        vecs.push_back(mk("lim_b4",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 0, 2, 2'b11));
        vecs.push_back(mk("lim_b5",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 0, 2, 2'b11));
        // clamp len 0 -> 1, with in_valid gaps
        vecs.push_back(mk("c0_cfg",     0, 1, 8'h01, 0,  0,  0,  0, 0, 0, 0, 2, 2'b11));
        vecs.push_back(mk("c0_arm",     0, 0, 8'h00, 0,  0,  1,  0, 0, 0, 0, 2, 2'b01));
        vecs.push_back(mk("c0_b1",      0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 0, 2'b10));
        vecs.push_back(mk("c0_gap1",    0, 0, 8'h00, 0,  0,  0,  0, 0, 1, 0, 1, 2'b10));
        vecs.push_back(mk("c0_b0",      0, 0, 8'h00, 0,  0,  0,  0, 1, 0, 0, 1, 2'b10));
        vecs.push_back(mk("c0_b1b",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 1, 2'b10));
        vecs.push_back(mk("c0_gap2",    0, 0, 8'h00, 0,  0,  0,  0, 0, 1, 0, 2, 2'b10));
        vecs.push_back(mk("c0_b1c",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 2, 2'b10));
        vecs.push_back(mk("c0_disarm",  0, 0, 8'h00, 0,  0,  0,  1, 0, 0, 0, 3, 2'b10));
        // clamp len 15 -> 8: eight ones needed
        vecs.push_back(mk("c15_cfg",    0, 1, 8'hff, 15, 0,  0,  0, 0, 0, 0, 3, 2'b01));
        vecs.push_back(mk("c15_arm",    0, 0, 8'h00, 0,  0,  1,  0, 0, 0, 0, 3, 2'b01));
        for (int i = 0; i < 7; i++) begin
            vecs.push_back(mk($sformatf("c15_b%0d", i + 1),
                              0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b10));
        end
        vecs.push_back(mk("c15_b8",     0, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 0, 2'b10));
        // synchronous reset while armed
        vecs.push_back(mk("mid_rst",    1, 0, 8'h00, 0,  0,  0,  0, 1, 1, 1, 1, 2'b10));
        vecs.push_back(mk("post_rst",   0, 0, 8'h00, 0,  0,  0,  0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk("post_arm",   0, 0, 8'h00, 0,  0,  1,  0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk("post_idle",  0, 0, 8'h00, 0,  0,  0,  0, 0, 0, 0, 0, 2'b00));

        foreach (vecs[i]) apply(vecs[i]);

        // Stall while armed, disarm colliding with a limit hit, cfg vs arm, arm vs disarm.
        apply(mk("h_cfg",       0, 1, 8'h03, 2, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        apply(mk("h_arm",       0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01));
        apply(mk("h_b1",        0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b10));
        apply(mk("h_stall1",    0, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0, 0, 2'b10));
        apply(mk("h_stall2",    0, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0, 0, 2'b10));
        apply(mk("h_dis_hit",   0, 1, 8'h00, 3, 0, 0, 1, 1, 1, 1, 0, 2'b10));
        apply(mk("h_cfg_arm",   0, 1, 8'h03, 2, 0, 1, 0, 0, 0, 0, 1, 2'b11));
        apply(mk("h_cfg_won",   0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01));
        apply(mk("h_arm2",      0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1, 2'b01));
        apply(mk("h_arm_dis",   0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 2'b10));
        apply(mk("h_dis_won",   0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
